// File: rtl/stack_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stack_alu_pkg
// Brief    : Opcodes and stack-pointer width shared by stack_based_alu users.
// Revision : 1.0 - initial release
// ============================================================================
package stack_alu_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam int SP_W = 5;

endpackage
`default_nettype wire

// File: rtl/stack_based_alu.sv
`default_nettype none
// ============================================================================
// Module   : stack_based_alu
// Brief    : LIFO stack of signed words with an add/multiply on the top two.
// Revision : 1.0 - initial release
// ============================================================================
module stack_based_alu
    import stack_alu_pkg::*;
#(
    parameter int n     = 32,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      opcode,
    input  logic [n-1:0]    input_data,
    output logic [n-1:0]    output_data,
    output logic [SP_W-1:0] sp,
    output logic            overflow
);

    localparam int            c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SP_W-1:0] c_DEPTH_SP = SP_W'(DEPTH);

    logic [n-1:0]      r_mem [DEPTH];

    logic [c_AW-1:0]   w_push_idx;
    logic [c_AW-1:0]   w_top_idx;
    logic [c_AW-1:0]   w_sec_idx;
    logic              w_push;
    logic              w_pop;
    logic              w_two;
    logic signed [n-1:0]   w_a;
    logic signed [n-1:0]   w_b;
    logic signed [n-1:0]   w_sum;
    logic                  w_add_ov;
    logic signed [2*n-1:0] w_ax;
    logic signed [2*n-1:0] w_bx;
    logic signed [2*n-1:0] w_prod;
    logic                  w_mul_ov;

    assign w_push_idx = c_AW'(sp);
    assign w_top_idx  = c_AW'(sp - SP_W'(1));
    assign w_sec_idx  = c_AW'(sp - SP_W'(2));

    assign w_push = (opcode == OP_PUSH) && (sp < c_DEPTH_SP);
    assign w_pop  = (opcode == OP_POP)  && (sp != '0);
    assign w_two  = (sp >= SP_W'(2));

    // Operand reads wrap harmlessly when sp < 2; results are only used when w_two.
    assign w_a = r_mem[w_top_idx];
    assign w_b = r_mem[w_sec_idx];

    assign w_sum    = w_a + w_b;
    assign w_add_ov = (w_a[n-1] == w_b[n-1]) && (w_sum[n-1] != w_a[n-1]);

    // Full-width signed product; overflow when the upper half is not a sign extension.
    assign w_ax     = {{n{w_a[n-1]}}, w_a};
    assign w_bx     = {{n{w_b[n-1]}}, w_b};
    assign w_prod   = w_ax * w_bx;
    assign w_mul_ov = (w_prod[2*n-1:n] != {n{w_prod[n-1]}});

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push_idx == c_AW'(i)) begin
                    r_mem[i] <= input_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp          <= '0;
            output_data <= '0;
            overflow    <= 1'b0;
        end else begin
            case (opcode)
                OP_PUSH: begin
                    if (w_push) begin
                        sp <= sp + SP_W'(1);
                    end
                end
                OP_POP: begin
                    if (w_pop) begin
                        output_data <= r_mem[w_top_idx];
                        sp          <= sp - SP_W'(1);
                    end
                end
                OP_ADD: begin
                    if (w_two) begin
                        output_data <= w_sum;
                        overflow    <= w_add_ov;
                    end
                end
                OP_MUL: begin
                    if (w_two) begin
                        output_data <= w_prod[n-1:0];
                        overflow    <= w_mul_ov;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stack_based_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_based_alu
// Brief    : Directed scoreboard bench for 32-bit and 8-bit stack_based_alu.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_based_alu;
    import stack_alu_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] out;
        logic [4:0]  sp;
        logic        ov;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [2:0]  op32;
    logic [31:0] din32;
    logic [31:0] out32;
    logic [4:0]  sp32;
    logic        ov32;
    logic [2:0]  op8;
    logic [7:0]  din8;
    logic [7:0]  out8;
    logic [4:0]  sp8;
    logic        ov8;

    exp_t sb[$];
    int   checks;
    int   failures;

    stack_based_alu #(.n(32), .DEPTH(16)) u_dut32 (
        .clk         (clk),
        .rst         (rst),
        .opcode      (op32),
        .input_data  (din32),
        .output_data (out32),
        .sp          (sp32),
        .overflow    (ov32)
    );

    stack_based_alu #(.n(8), .DEPTH(16)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .opcode      (op8),
        .input_data  (din8),
        .output_data (out8),
        .sp          (sp8),
        .overflow    (ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one op on the selected instance, clock it, then compare against the queued expectation.
    task automatic step(input bit sel8, input logic r, input logic [2:0] op, input logic [31:0] d,
                        input logic [31:0] eo, input logic [4:0] es, input logic eov, input string tag);
        exp_t e;
        e.tag = tag; e.out = eo; e.sp = es; e.ov = eov;
        sb.push_back(e);
        rst = r;
        if (sel8) begin
            op8 = op; din8 = d[7:0]; op32 = OP_NOP;
        end else begin
            op32 = op; din32 = d; op8 = OP_NOP;
        end
        @(posedge clk);
        #1;
        rst = 1'b0; op32 = OP_NOP; op8 = OP_NOP;
        e = sb.pop_front();
        if (sel8) begin
            check({e.tag, ".out"}, {24'b0, out8}, e.out);
            check({e.tag, ".sp"},  {27'b0, sp8},  {27'b0, e.sp});
            check({e.tag, ".ov"},  {31'b0, ov8},  {31'b0, e.ov});
        end else begin
            check({e.tag, ".out"}, out32,         e.out);
            check({e.tag, ".sp"},  {27'b0, sp32}, {27'b0, e.sp});
            check({e.tag, ".ov"},  {31'b0, ov32}, {31'b0, e.ov});
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0; op32 = OP_NOP; din32 = '0; op8 = OP_NOP; din8 = '0;
        @(posedge clk); #1;

        step(0, 1, OP_NOP, 0, 32'h0, 0, 0, "reset");
        step(0, 0, OP_POP, 0, 32'h0, 0, 0, "pop_empty");

        // 8-bit operator stack
        step(1, 0, OP_PUSH, 32'h28, 32'h00, 1, 0, "b8_push_lp");
        step(1, 0, OP_PUSH, 32'h2B, 32'h00, 2, 0, "b8_push_plus");
        step(1, 0, OP_POP,  0,      32'h2B, 1, 0, "b8_pop_plus");
        step(1, 0, OP_POP,  0,      32'h28, 0, 0, "b8_pop_lp");
        step(1, 0, OP_POP,  0,      32'h28, 0, 0, "b8_pop_empty");
        step(1, 0, OP_PUSH, 32'h7F, 32'h28, 1, 0, "b8_push_7f");
        step(1, 0, OP_PUSH, 32'h01, 32'h28, 2, 0, "b8_push_01");
        step(1, 0, OP_ADD,  0,      32'h80, 2, 1, "b8_add_ovf");
        step(1, 0, OP_PUSH, 32'hF0, 32'h80, 3, 1, "b8_push_f0");
        step(1, 0, OP_PUSH, 32'h08, 32'h80, 4, 1, "b8_push_08");
        step(1, 0, OP_MUL,  0,      32'h80, 4, 0, "b8_mul_min");

        // 32-bit evaluation stack
        step(0, 0, OP_PUSH, 32'd7,        32'h0,        1, 0, "push7");
        step(0, 0, OP_PUSH, 32'hFFFFFFFD, 32'h0,        2, 0, "push_m3");
        step(0, 0, OP_ADD,  0,            32'd4,        2, 0, "add");
        step(0, 0, OP_MUL,  0,            32'hFFFFFFEB, 2, 0, "mul");
        step(0, 0, OP_POP,  0,            32'hFFFFFFFD, 1, 0, "pop_m3");
        step(0, 0, OP_POP,  0,            32'd7,        0, 0, "pop7");

        step(0, 0, OP_PUSH, 32'd2, 32'd7, 1, 0, "calc_push2");
        step(0, 0, OP_PUSH, 32'd3, 32'd7, 2, 0, "calc_push3");
        step(0, 0, OP_MUL,  0,     32'd6, 2, 0, "calc_mul");
        step(0, 0, OP_POP,  0,     32'd3, 1, 0, "calc_pop3");
        step(0, 0, OP_POP,  0,     32'd2, 0, 0, "calc_pop2");
        step(0, 0, OP_PUSH, 32'd6, 32'd2, 1, 0, "calc_push6");
        step(0, 0, OP_POP,  0,     32'd6, 0, 0, "calc_pop6");

        step(0, 0, OP_PUSH, 32'h7FFFFFFF, 32'd6,        1, 0, "push_max");
        step(0, 0, OP_PUSH, 32'd1,        32'd6,        2, 0, "push_1");
        step(0, 0, OP_ADD,  0,            32'h80000000, 2, 1, "add_ovf");
        step(0, 0, OP_PUSH, 32'h10000,    32'h80000000, 3, 1, "push_64k");
        step(0, 0, OP_MUL,  0,            32'h10000,    3, 0, "mul_noovf");
        step(0, 0, OP_PUSH, 32'h10000,    32'h10000,    4, 0, "push_64k_b");
        step(0, 0, OP_MUL,  0,            32'h0,        4, 1, "mul_ovf");

        step(0, 1, OP_NOP,  0,     32'h0, 0, 0, "reset2");
        step(0, 0, OP_PUSH, 32'd5, 32'h0, 1, 0, "push5");
        step(0, 0, OP_ADD,  0,     32'h0, 1, 0, "add_short");
        step(0, 0, OP_MUL,  0,     32'h0, 1, 0, "mul_short");
        for (int k = 1; k <= 15; k++) begin
            step(0, 0, OP_PUSH, 32'(100 + k), 32'h0, 5'(1 + k), 0, "fill");
        end
        step(0, 0, OP_PUSH, 32'd999, 32'h0,   16, 0, "push_full");
        step(0, 0, OP_POP,  0,       32'd115, 15, 0, "pop_after_full");
        step(0, 0, OP_PUSH, 32'd116, 32'd115, 16, 0, "refill");
        step(0, 1, OP_PUSH, 32'd77,  32'h0,   0,  0, "reset_push");
        step(0, 0, OP_POP,  0,       32'h0,   0,  0, "pop_after_reset");
        step(0, 0, OP_PUSH, 32'd42,  32'h0,   1,  0, "push42");
        step(0, 0, OP_POP,  0,       32'd42,  0,  0, "pop42");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
